// File: rtl/adsr_env32.sv
// -----------------------------------------------------------------------------
// adsr_env32 -- four-segment linear ADSR envelope generator.
//
// Produces the 32-bit unsigned control-voltage word that drives the VCAs.
// A note is started by a rising edge on gate and ended by a falling edge.
// The envelope level moves by one rate step per audio-sample strobe.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset
//   sample_en    in   one-cycle audio-sample strobe (level step enable)
//   gate         in   note gate, synchronous to clk, edges detected here
//   attack_inc   in   WIDTH  added per tick in ATTACK   (0 = instant)
//   decay_dec    in   WIDTH  subtracted per tick in DECAY (0 = instant)
//   sustain      in   WIDTH  sustain level, followed live in SUSTAIN
//   release_dec  in   WIDTH  subtracted per tick in RELEASE (0 = instant)
//   cv           out  WIDTH  envelope level, 0 = silence, all ones = full
//   state        out  3      IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy         out  1      state is not IDLE
//   eoc          out  1      one-clock pulse when RELEASE reaches 0
//
// Configuration macro: ADSR_LEGATO_EN
//   defined   : a rising gate edge outside IDLE re-enters ATTACK from the
//               current level (no discontinuity).
//   undefined : a rising gate edge outside IDLE forces the level to 0 and
//               re-enters ATTACK (hard retrigger).
//
// Only WIDTH = 32 is supported.
// -----------------------------------------------------------------------------
module adsr_env32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             gate,
  input  logic [WIDTH-1:0] attack_inc,
  input  logic [WIDTH-1:0] decay_dec,
  input  logic [WIDTH-1:0] sustain,
  input  logic [WIDTH-1:0] release_dec,
  output logic [WIDTH-1:0] cv,
  output logic [2:0]       state,
  output logic             busy,
  output logic             eoc
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_e;

  localparam logic [WIDTH-1:0] FULL_SCALE = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cv_q, cv_d;
  logic             eoc_q, eoc_d;
  logic             gate_q;

  logic             gate_rise;
  logic             gate_fall;
  logic             in_note;
  logic [WIDTH:0]   attack_sum;

  // ---------------------------------------------------------------------------
  // Saturating arithmetic helpers. All sums are formed one bit wider than the
  // level so that overflow is visible and the level can never wrap.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH:0] ext_add(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Attack ends when the next step would reach or pass full scale.
  function automatic logic attack_done(input logic [WIDTH-1:0] lvl,
                                       input logic [WIDTH-1:0] inc);
    return (inc == '0) || (ext_add(lvl, inc) >= {1'b0, FULL_SCALE});
  endfunction

  // Decay ends when one more step would land on or below the sustain level.
  // The compare is done against sustain + dec so that no subtraction can
  // underflow when sustain is close to zero.
  function automatic logic decay_done(input logic [WIDTH-1:0] lvl,
                                      input logic [WIDTH-1:0] dec,
                                      input logic [WIDTH-1:0] sus);
    return (dec == '0) || ({1'b0, lvl} <= ext_add(sus, dec));
  endfunction

  // Release ends when one more step would land on or below zero.
  function automatic logic release_done(input logic [WIDTH-1:0] lvl,
                                        input logic [WIDTH-1:0] dec);
    return (dec == '0) || (lvl <= dec);
  endfunction

  // ---------------------------------------------------------------------------
  // Gate edge detection against the one-clock delayed copy of gate.
  // ---------------------------------------------------------------------------
  assign gate_rise  = gate & ~gate_q;
  assign gate_fall  = ~gate & gate_q;
  assign in_note    = (state_q == S_ATTACK) || (state_q == S_DECAY) ||
                      (state_q == S_SUSTAIN);
  assign attack_sum = ext_add(cv_q, attack_inc);

  // ---------------------------------------------------------------------------
  // Next-state logic. Gate transitions take priority over level steps: in a
  // cycle where a gate edge changes the state, the level is not stepped.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cv_d    = cv_q;
    eoc_d   = 1'b0;

    if (gate_rise) begin
      state_d = S_ATTACK;
      if (state_q == S_IDLE) begin
        cv_d = '0;
      end else begin
`ifdef ADSR_LEGATO_EN
        cv_d = cv_q;
`else
        cv_d = '0;
`endif
      end
    end else if (gate_fall && in_note) begin
      // Release starts from wherever the level currently is.
      state_d = S_RELEASE;
    end else if (sample_en) begin
      case (state_q)
        S_IDLE: begin
          cv_d = '0;
        end
        S_ATTACK: begin
          if (attack_done(cv_q, attack_inc)) begin
            cv_d    = FULL_SCALE;
            state_d = S_DECAY;
          end else begin
            cv_d = attack_sum[WIDTH-1:0];
          end
        end
        S_DECAY: begin
          if (decay_done(cv_q, decay_dec, sustain)) begin
            cv_d    = sustain;
            state_d = S_SUSTAIN;
          end else begin
            cv_d = cv_q - decay_dec;
          end
        end
        S_SUSTAIN: begin
          // Track live sustain changes directly, no slew.
          cv_d = sustain;
        end
        S_RELEASE: begin
          if (release_done(cv_q, release_dec)) begin
            cv_d    = '0;
            state_d = S_IDLE;
            eoc_d   = 1'b1;
          end else begin
            cv_d = cv_q - release_dec;
          end
        end
        default: begin
          cv_d    = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset is asynchronous so a mid-envelope reset silences
  // the output immediately, without waiting for a clock edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cv_q    <= '0;
      eoc_q   <= 1'b0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cv_q    <= cv_d;
      eoc_q   <= eoc_d;
      gate_q  <= gate;
    end
  end

  assign cv    = cv_q;
  assign state = state_q;
  assign eoc   = eoc_q;
  // Decoded straight from the state register so it never lags state.
  assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_adsr_env32.sv
module tb_adsr_env32;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ATK  = 3'd1;
  localparam logic [2:0] S_DEC  = 3'd2;
  localparam logic [2:0] S_SUS  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_en = 1'b0;
  logic        gate = 1'b0;
  logic [31:0] attack_inc = '0;
  logic [31:0] decay_dec = '0;
  logic [31:0] sustain = '0;
  logic [31:0] release_dec = '0;
  logic [31:0] cv;
  logic [2:0]  state;
  logic        busy;
  logic        eoc;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [31:0] cv;
    logic        eoc;
  } exp_t;

  // One stimulus step: idle cycles at the current gate level, then one
  // cycle driving se/g, optionally with a new sustain value applied first.
  typedef struct {
    int          idle;
    logic        se;
    logic        g;
    logic        chg_sus;
    logic [31:0] sus;
    exp_t        e;
  } step_t;

  exp_t  sb[$];
  step_t plan[$];

  always #5 clk = ~clk;

  adsr_env32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .gate        (gate),
    .attack_inc  (attack_inc),
    .decay_dec   (decay_dec),
    .sustain     (sustain),
    .release_dec (release_dec),
    .cv          (cv),
    .state       (state),
    .busy        (busy),
    .eoc         (eoc)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic cyc(input logic se, input logic g);
    sample_en = se;
    gate      = g;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  task automatic do_reset();
    gate      = 1'b0;
    sample_en = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic plan_add(input int idle, input logic se, input logic g,
                          input logic [2:0] st, input logic [31:0] v,
                          input logic eo);
    step_t s;
    s.idle = idle; s.se = se; s.g = g; s.chg_sus = 1'b0; s.sus = '0;
    s.e = '{st: st, cv: v, eoc: eo};
    plan.push_back(s);
  endtask

  task automatic plan_add_sus(input int idle, input logic se, input logic g,
                              input logic [31:0] new_sus, input logic [2:0] st,
                              input logic [31:0] v, input logic eo);
    step_t s;
    s.idle = idle; s.se = se; s.g = g; s.chg_sus = 1'b1; s.sus = new_sus;
    s.e = '{st: st, cv: v, eoc: eo};
    plan.push_back(s);
  endtask

  task automatic set_rates(input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] s, input logic [31:0] r);
    attack_inc = a; decay_dec = d; sustain = s; release_dec = r;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    sb.push_back('{st: S_IDLE, cv: 32'h0, eoc: 1'b0});
    e = sb.pop_front();
    n_total++;
    if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== 1'b0)
      $display("FAIL reset_values: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b busy=0",
               state, cv, eoc, busy, e.st, e.cv, e.eoc);
    else n_pass++;

    // Run into DECAY, then pull reset between clock edges.
    set_rates(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h4000_0000);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'hC000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hFFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hEFFF_FFFF, 1'b0);
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL reset_pre[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end

    rst_n = 1'b0;
    sb.push_back('{st: S_IDLE, cv: 32'h0, eoc: 1'b0});
    #1;
    e = sb.pop_front();
    n_total++;
    if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== 1'b0)
      $display("FAIL async_reset: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b busy=0",
               state, cv, eoc, busy, e.st, e.cv, e.eoc);
    else n_pass++;

    gate = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL reset_post[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_envelope();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    set_rates(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h4000_0000);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'hC000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hFFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hEFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hDFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hCFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_SUS, 32'hC000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_SUS, 32'hC000_0000, 1'b0);
    plan_add(0, 1'b0, 1'b0, S_REL, 32'hC000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_REL, 32'h8000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_REL, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_IDLE, 32'h0000_0000, 1'b1);
    plan_add(0, 1'b0, 1'b0, S_IDLE, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_IDLE, 32'h0000_0000, 1'b0);
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL full_env[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_zero_rates();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    set_rates(32'h0, 32'h0, 32'h1234_5678, 32'h0);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_DEC, 32'hFFFF_FFFF, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_SUS, 32'h1234_5678, 1'b0);
    // Live sustain change is followed on the next tick with no slew.
    plan_add_sus(3, 1'b1, 1'b1, 32'h2222_0000, S_SUS, 32'h2222_0000, 1'b0);
    plan_add(0, 1'b0, 1'b0, S_REL, 32'h2222_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_IDLE, 32'h0000_0000, 1'b1);
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL zero_rates[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_early_release();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    set_rates(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h4000_0000);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
    plan_add(0, 1'b0, 1'b0, S_REL, 32'h8000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_REL, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_IDLE, 32'h0000_0000, 1'b1);
    // Gate dropped before the first attack tick.
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(0, 1'b0, 1'b0, S_REL, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_IDLE, 32'h0000_0000, 1'b1);
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL early_release[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_retrigger();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    set_rates(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h4000_0000);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
    plan_add(0, 1'b0, 1'b0, S_REL, 32'h8000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b0, S_REL, 32'h4000_0000, 1'b0);
`ifdef ADSR_LEGATO_EN
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
`else
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
`endif
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL retrigger[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_simultaneous();
    exp_t  e;
    step_t s;
    int    k;
    do_reset();
    set_rates(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h4000_0000);
    plan_add(0, 1'b0, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    // Falling edge together with a tick: state moves, level held.
    plan_add(3, 1'b1, 1'b0, S_REL, 32'h4000_0000, 1'b0);
    // Rising edge together with a tick in RELEASE.
`ifdef ADSR_LEGATO_EN
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h8000_0000, 1'b0);
`else
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h0000_0000, 1'b0);
    plan_add(3, 1'b1, 1'b1, S_ATK, 32'h4000_0000, 1'b0);
`endif
    k = 0;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      for (int i = 0; i < s.idle; i++) cyc(1'b0, gate);
      if (s.chg_sus) sustain = s.sus;
      sb.push_back(s.e);
      cyc(s.se, s.g);
      e = sb.pop_front();
      n_total++;
      if (cv !== e.cv || state !== e.st || eoc !== e.eoc || busy !== (e.st != S_IDLE))
        $display("FAIL simultaneous[%0d]: got st=%0d cv=%h eoc=%b busy=%b, required st=%0d cv=%h eoc=%b",
                 k, state, cv, eoc, busy, e.st, e.cv, e.eoc);
      else n_pass++;
      k++;
    end
  endtask

  initial begin
    test_reset();
    test_full_envelope();
    test_zero_rates();
    test_early_release();
    test_retrigger();
    test_simultaneous();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
